axis_slave_data_rec_stall: RTL and testbench

- Parametrised AXI4-Stream sink for kernel testbenches; successor to the fixed 1024-word, one-shot-stall receiver.
- Captures beats into an internal buffer and applies a periodic, programmable back-pressure pattern.
- Counts beats and TLAST-delimited packets, flags overflow attempts, and exposes a synchronous read-back port so the bench can check captured data.

---
 rtl/axis_slave_data_rec_stall.sv | 210 +++++++++++++++++++++
 tb/tb_axis_slave_data_rec_stall.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_slave_data_rec_stall.sv
// -----------------------------------------------------------------------------
// axis_slave_data_rec_stall
//
// AXI4-Stream sink for kernel testbenches. Captures every accepted beat (data
// plus strobe) into an internal buffer, applies a periodic back-pressure
// pattern, counts beats and TLAST-delimited packets, flags attempts to push
// into a full buffer, and offers a synchronous read-back port.
//
// Ports:
//   S_AXIS_ACLK    - clock, everything on the rising edge
//   S_AXIS_ARESET  - synchronous active-high reset
//   S_AXIS_TREADY  - sink ready (combinational from state, CLEAR, reset)
//   S_AXIS_TDATA   - stream data
//   S_AXIS_TSTRB   - byte qualifier, stored next to the data
//   S_AXIS_TLAST   - packet boundary, counted but never ends capture
//   S_AXIS_TVALID  - source valid
//   CLEAR          - restart capture (counters/flags clear, buffer kept)
//   RD_ADDR        - read-back address
//   RD_DATA/STRB   - read-back data/strobe, one cycle after RD_ADDR
//   BEAT_COUNT     - beats captured since reset/CLEAR
//   PKT_COUNT      - TLAST beats captured, wraps
//   DONE           - buffer full
//   OVERFLOW       - sticky, TVALID seen while full
//   STALL_ACTIVE   - high during a back-pressure window
// -----------------------------------------------------------------------------
module axis_slave_data_rec_stall #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int DEPTH                = 1024,
  parameter int STALL_EVERY          = 4,
  parameter int STALL_CYCLES         = 100,
  parameter int PKT_CNT_WIDTH        = 16
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  input  logic                                CLEAR,
  input  logic [$clog2(DEPTH)-1:0]            RD_ADDR,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     RD_DATA,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   RD_STRB,
  output logic [$clog2(DEPTH):0]              BEAT_COUNT,
  output logic [PKT_CNT_WIDTH-1:0]            PKT_COUNT,
  output logic                                DONE,
  output logic                                OVERFLOW,
  output logic                                STALL_ACTIVE
);

  localparam int W   = C_S_AXIS_TDATA_WIDTH;
  localparam int SBW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  // Since-stall counter must hold STALL_EVERY itself; keep 1 bit when disabled.
  localparam int SEW = (STALL_EVERY < 1) ? 1 : $clog2(STALL_EVERY + 1);
  localparam int SCW = $clog2(STALL_CYCLES + 1);

  localparam logic [AW:0]    DEPTH_C = AW1'(DEPTH);
  localparam logic [SEW-1:0] SE_C    = SEW'(STALL_EVERY);
  localparam logic [SCW-1:0] SC_C    = SCW'(STALL_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_STALL = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [AW:0]              beat_q, beat_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [SEW-1:0]           since_q, since_d;
  logic [SCW-1:0]           stall_q, stall_d;
  logic                     ovf_q, ovf_d;
  logic [W-1:0]             rd_data_q;
  logic [SBW-1:0]           rd_strb_q;

  logic [W-1:0]             data_mem [DEPTH];
  logic [SBW-1:0]           strb_mem [DEPTH];

  logic                     tready_s;
  logic                     accept_s;
  logic [AW:0]              beat_inc_s;
  logic [SEW-1:0]           since_inc_s;

  // Ready is withheld in the CLEAR/reset cycle so nothing lands while restarting.
  assign tready_s    = (state_q == ST_RECV) && !CLEAR && !S_AXIS_ARESET;
  assign accept_s    = tready_s && S_AXIS_TVALID;
  assign beat_inc_s  = beat_q + AW1'(1);
  assign since_inc_s = since_q + SEW'(1);

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    since_d = since_q;
    stall_d = stall_q;
    ovf_d   = ovf_q;
    if (CLEAR) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      pkt_d   = '0;
      since_d = '0;
      stall_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (S_AXIS_TVALID) begin
            state_d = ST_RECV;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RECV: begin
          if (accept_s) begin
            beat_d = beat_inc_s;
            if (S_AXIS_TLAST) begin
              pkt_d = pkt_q + PKT_CNT_WIDTH'(1);
            end else begin
              pkt_d = pkt_q;
            end
            // Filling the buffer wins over starting a stall window.
            if (beat_inc_s == DEPTH_C) begin
              state_d = ST_FULL;
            end else if ((STALL_EVERY != 0) && (since_inc_s == SE_C)) begin
              state_d = ST_STALL;
              since_d = '0;
              stall_d = SC_C;
            end else begin
              since_d = since_inc_s;
            end
          end else begin
            state_d = ST_RECV;
          end
        end
        ST_STALL: begin
          // Loaded with STALL_CYCLES; leaving on the value 1 gives exactly
          // STALL_CYCLES cycles in this state.
          if (stall_q <= SCW'(1)) begin
            state_d = ST_RECV;
            stall_d = '0;
          end else begin
            stall_d = stall_q - SCW'(1);
          end
        end
        ST_FULL: begin
          if (S_AXIS_TVALID) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state and counters.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      pkt_q   <= '0;
      since_q <= '0;
      stall_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      since_q <= since_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  // Capture buffer; contents deliberately survive reset and CLEAR.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (accept_s) begin
      data_mem[beat_q[AW-1:0]] <= S_AXIS_TDATA;
      strb_mem[beat_q[AW-1:0]] <= S_AXIS_TSTRB;
    end
  end

  // Registered read-back port; a same-address write returns the old word.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      rd_data_q <= '0;
      rd_strb_q <= '0;
    end else begin
      rd_data_q <= data_mem[RD_ADDR];
      rd_strb_q <= strb_mem[RD_ADDR];
    end
  end

  assign S_AXIS_TREADY = tready_s;
  assign RD_DATA       = rd_data_q;
  assign RD_STRB       = rd_strb_q;
  assign BEAT_COUNT    = beat_q;
  assign PKT_COUNT     = pkt_q;
  assign DONE          = (state_q == ST_FULL);
  assign OVERFLOW      = ovf_q;
  assign STALL_ACTIVE  = (state_q == ST_STALL);

endmodule

// File: tb/tb_axis_slave_data_rec_stall.sv
// -----------------------------------------------------------------------------
// Bench for axis_slave_data_rec_stall. Three instances:
//   A: DEPTH=1024, STALL_EVERY=4, STALL_CYCLES=100
//   B: DEPTH=16,   STALL_EVERY=0
//   C: DEPTH=16,   STALL_EVERY=4, STALL_CYCLES=100
// Inputs are driven just after the falling edge, outputs sampled #1 later
// (TREADY is combinational) or on the following falling edge.
// -----------------------------------------------------------------------------
module tb_axis_slave_data_rec_stall;
  localparam int W  = 32;
  localparam int SB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic          a_rst, a_tvalid, a_tlast, a_clear, a_tready, a_done, a_ovf, a_stall;
  logic [W-1:0]  a_tdata, a_rd_data;
  logic [SB-1:0] a_tstrb, a_rd_strb;
  logic [9:0]    a_rd_addr;
  logic [10:0]   a_beats;
  logic [15:0]   a_pkts;

  logic          b_rst, b_tvalid, b_tlast, b_clear, b_tready, b_done, b_ovf, b_stall;
  logic [W-1:0]  b_tdata, b_rd_data;
  logic [SB-1:0] b_tstrb, b_rd_strb;
  logic [3:0]    b_rd_addr;
  logic [4:0]    b_beats;
  logic [15:0]   b_pkts;

  logic          c_rst, c_tvalid, c_tlast, c_clear, c_tready, c_done, c_ovf, c_stall;
  logic [W-1:0]  c_tdata, c_rd_data;
  logic [SB-1:0] c_tstrb, c_rd_strb;
  logic [3:0]    c_rd_addr;
  logic [4:0]    c_beats;
  logic [15:0]   c_pkts;

  // Reference copy of instance A's buffer, filled from the bench's own accepts.
  logic [W-1:0]  a_mem_m  [1024];
  logic [SB-1:0] a_strb_m [1024];

  axis_slave_data_rec_stall #(.C_S_AXIS_TDATA_WIDTH(32), .DEPTH(1024), .STALL_EVERY(4),
                              .STALL_CYCLES(100), .PKT_CNT_WIDTH(16)) u_a (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(a_rst), .S_AXIS_TREADY(a_tready),
    .S_AXIS_TDATA(a_tdata), .S_AXIS_TSTRB(a_tstrb), .S_AXIS_TLAST(a_tlast),
    .S_AXIS_TVALID(a_tvalid), .CLEAR(a_clear), .RD_ADDR(a_rd_addr),
    .RD_DATA(a_rd_data), .RD_STRB(a_rd_strb), .BEAT_COUNT(a_beats),
    .PKT_COUNT(a_pkts), .DONE(a_done), .OVERFLOW(a_ovf), .STALL_ACTIVE(a_stall));

  axis_slave_data_rec_stall #(.C_S_AXIS_TDATA_WIDTH(32), .DEPTH(16), .STALL_EVERY(0),
                              .STALL_CYCLES(100), .PKT_CNT_WIDTH(16)) u_b (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(b_rst), .S_AXIS_TREADY(b_tready),
    .S_AXIS_TDATA(b_tdata), .S_AXIS_TSTRB(b_tstrb), .S_AXIS_TLAST(b_tlast),
    .S_AXIS_TVALID(b_tvalid), .CLEAR(b_clear), .RD_ADDR(b_rd_addr),
    .RD_DATA(b_rd_data), .RD_STRB(b_rd_strb), .BEAT_COUNT(b_beats),
    .PKT_COUNT(b_pkts), .DONE(b_done), .OVERFLOW(b_ovf), .STALL_ACTIVE(b_stall));

  axis_slave_data_rec_stall #(.C_S_AXIS_TDATA_WIDTH(32), .DEPTH(16), .STALL_EVERY(4),
                              .STALL_CYCLES(100), .PKT_CNT_WIDTH(16)) u_c (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(c_rst), .S_AXIS_TREADY(c_tready),
    .S_AXIS_TDATA(c_tdata), .S_AXIS_TSTRB(c_tstrb), .S_AXIS_TLAST(c_tlast),
    .S_AXIS_TVALID(c_tvalid), .CLEAR(c_clear), .RD_ADDR(c_rd_addr),
    .RD_DATA(c_rd_data), .RD_STRB(c_rd_strb), .BEAT_COUNT(c_beats),
    .PKT_COUNT(c_pkts), .DONE(c_done), .OVERFLOW(c_ovf), .STALL_ACTIVE(c_stall));

  // With TVALID held from cycle 0, beat k is taken at 1 + k + 100*(k/4).
  function automatic bit a_accept_cycle(int c);
    for (int k = 0; k < 8; k++) begin
      if (c == 1 + k + (k / 4) * 100) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    #1;
    checks++;
    if ({a_tready, a_done, a_ovf, a_stall, a_beats, a_pkts, a_rd_data, a_rd_strb} !== '0) begin
      failures++;
      $display("FAIL reset_a rdy=%b done=%b ovf=%b stall=%b beats=%0d pkts=%0d rd=%h/%h required all zero",
               a_tready, a_done, a_ovf, a_stall, a_beats, a_pkts, a_rd_data, a_rd_strb);
    end
    checks++;
    if ({b_tready, b_done, b_ovf, b_stall, b_beats, b_pkts, b_rd_data, b_rd_strb} !== '0) begin
      failures++;
      $display("FAIL reset_b rdy=%b done=%b ovf=%b stall=%b beats=%0d pkts=%0d required all zero",
               b_tready, b_done, b_ovf, b_stall, b_beats, b_pkts);
    end
    checks++;
    if ({c_tready, c_done, c_ovf, c_stall, c_beats, c_pkts, c_rd_data, c_rd_strb} !== '0) begin
      failures++;
      $display("FAIL reset_c rdy=%b done=%b ovf=%b stall=%b beats=%0d pkts=%0d required all zero",
               c_tready, c_done, c_ovf, c_stall, c_beats, c_pkts);
    end
  endtask

  task automatic test_stall_pattern();
    int acc = 0;
    bit exp_r, exp_s;
    for (int c = 0; c <= 108; c++) begin
      @(negedge clk);
      a_tvalid = 1'b1; a_tdata = acc; a_tstrb = 4'hF; a_tlast = 1'b0;
      #1;
      exp_r = a_accept_cycle(c);
      exp_s = (c >= 1) && !exp_r;
      checks++;
      if (a_tready !== exp_r || a_stall !== exp_s) begin
        failures++;
        $display("FAIL stall_pattern cycle %0d: tready=%b stall=%b required tready=%b stall=%b",
                 c, a_tready, a_stall, exp_r, exp_s);
      end
      if (exp_r) begin
        a_mem_m[acc] = acc; a_strb_m[acc] = 4'hF; acc++;
      end
    end
    @(negedge clk);
    a_tvalid = 1'b0;
    #1;
    checks++;
    if (a_beats !== 11'd8 || a_stall !== 1'b1) begin
      failures++;
      $display("FAIL stall_pattern_count beats=%0d stall=%b required 8 and 1", a_beats, a_stall);
    end
    for (int k = 0; k < 8; k++) begin
      a_rd_addr = 10'(k);
      @(negedge clk);
      checks++;
      if (a_rd_data !== a_mem_m[k] || a_rd_strb !== a_strb_m[k]) begin
        failures++;
        $display("FAIL stall_pattern_read addr %0d: got %h/%h required %h/%h",
                 k, a_rd_data, a_rd_strb, a_mem_m[k], a_strb_m[k]);
      end
    end
  endtask

  task automatic test_tlast_random();
    int acc = 0, pk = 0, stall_left = 0, cyc = 0;
    bit started = 1'b0, exp_r;
    @(negedge clk);
    a_clear = 1'b1; a_tvalid = 1'b1;
    #1;
    checks++;
    if (a_tready !== 1'b0) begin
      failures++;
      $display("FAIL clear_blocks_ready tready=%b required 0", a_tready);
    end
    @(negedge clk);
    a_clear = 1'b0; a_tvalid = 1'b0;
    #1;
    checks++;
    if (a_beats !== 11'd0 || a_stall !== 1'b0 || a_tready !== 1'b0) begin
      failures++;
      $display("FAIL tlast_clear beats=%0d stall=%b tready=%b required 0/0/0", a_beats, a_stall, a_tready);
    end
    while (acc < 12 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      a_tvalid = 1'($urandom_range(0, 1));
      a_tdata  = $urandom;
      a_tstrb  = 4'($urandom);
      a_tlast  = ((acc % 3) == 2);
      #1;
      exp_r = started && (stall_left == 0);
      checks++;
      if (a_tready !== exp_r || a_stall !== (stall_left > 0)) begin
        failures++;
        $display("FAIL tlast_handshake cycle %0d: tready=%b stall=%b required tready=%b stall=%b",
                 cyc, a_tready, a_stall, exp_r, (stall_left > 0));
      end
      if (stall_left > 0) stall_left--;
      if (a_tvalid && exp_r) begin
        a_mem_m[acc] = a_tdata; a_strb_m[acc] = a_tstrb;
        acc++;
        if (a_tlast) pk++;
        if (acc % 4 == 0) stall_left = 100;
      end
      if (a_tvalid) started = 1'b1;
    end
    checks++;
    if (acc != 12) begin
      failures++;
      $display("FAIL tlast_timeout accepted %0d beats required 12", acc);
    end
    @(negedge clk);
    a_tvalid = 1'b0; a_tlast = 1'b0;
    #1;
    checks++;
    if (a_pkts !== 16'(pk) || a_beats !== 11'(acc) || a_done !== 1'b0 || a_stall !== 1'b1) begin
      failures++;
      $display("FAIL tlast_counts pkts=%0d beats=%0d done=%b stall=%b required %0d/%0d/0/1",
               a_pkts, a_beats, a_done, a_stall, pk, acc);
    end
    for (int i = 0; i < 12; i++) begin
      int ad;
      ad = $urandom_range(0, 11);
      a_rd_addr = 10'(ad);
      @(negedge clk);
      checks++;
      if (a_rd_data !== a_mem_m[ad] || a_rd_strb !== a_strb_m[ad]) begin
        failures++;
        $display("FAIL tlast_read addr %0d: got %h/%h required %h/%h",
                 ad, a_rd_data, a_rd_strb, a_mem_m[ad], a_strb_m[ad]);
      end
    end
  endtask

  task automatic test_reset_mid_recv();
    logic [W-1:0] d [2];
    d[0] = 32'h1111_0000; d[1] = 32'h2222_0001;
    @(negedge clk); a_clear = 1'b1;
    @(negedge clk); a_clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_tvalid = 1'b1; a_tstrb = 4'hF; a_tdata = (c >= 1) ? d[c-1] : 32'h0;
      #1;
      checks++;
      if (a_tready !== (c >= 1)) begin
        failures++;
        $display("FAIL reset_mid_pre cycle %0d: tready=%b required %b", c, a_tready, (c >= 1));
      end
      if (c >= 1) begin a_mem_m[c-1] = d[c-1]; a_strb_m[c-1] = 4'hF; end
    end
    @(negedge clk);
    a_rst = 1'b1; a_tvalid = 1'b1; a_tdata = 32'hDEAD_BEEF; a_tstrb = 4'h5; a_rd_addr = 10'd2;
    #1;
    checks++;
    if (a_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ready tready=%b required 0", a_tready);
    end
    @(negedge clk);
    a_rst = 1'b0; a_tvalid = 1'b0;
    #1;
    checks++;
    if (a_beats !== 11'd0 || a_pkts !== 16'd0 || a_rd_data !== 32'd0 || a_rd_strb !== 4'd0
        || a_stall !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state beats=%0d pkts=%0d rd=%h/%h stall=%b done=%b required zeros",
               a_beats, a_pkts, a_rd_data, a_rd_strb, a_stall, a_done);
    end
    for (int k = 2; k >= 0; k--) begin
      @(negedge clk);
      checks++;
      if (a_rd_data !== a_mem_m[k] || a_rd_strb !== a_strb_m[k]) begin
        failures++;
        $display("FAIL reset_mid_read addr %0d: got %h/%h required %h/%h",
                 k, a_rd_data, a_rd_strb, a_mem_m[k], a_strb_m[k]);
      end
      if (k > 0) a_rd_addr = 10'(k - 1);
    end
  endtask

  task automatic test_no_stall_full();
    int acc = 0;
    bit exp_r;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      b_tvalid = 1'b1; b_tdata = acc; b_tstrb = 4'hF; b_tlast = 1'b0;
      #1;
      exp_r = (c >= 1) && (c <= 16);
      checks++;
      if (b_tready !== exp_r || b_done !== (c >= 17) || b_ovf !== (c >= 18) || b_stall !== 1'b0) begin
        failures++;
        $display("FAIL nostall cycle %0d: tready=%b done=%b ovf=%b stall=%b required %b/%b/%b/0",
                 c, b_tready, b_done, b_ovf, b_stall, exp_r, (c >= 17), (c >= 18));
      end
      if (exp_r) acc++;
    end
    @(negedge clk);
    b_tvalid = 1'b0;
    b_rd_addr = 4'd0;
    #1;
    checks++;
    if (b_beats !== 5'd16 || b_ovf !== 1'b1 || b_tready !== 1'b0) begin
      failures++;
      $display("FAIL nostall_full beats=%0d ovf=%b tready=%b required 16/1/0", b_beats, b_ovf, b_tready);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (b_rd_data !== 32'(k) || b_rd_strb !== 4'hF) begin
        failures++;
        $display("FAIL nostall_read addr %0d: got %h/%h required %h/f", k, b_rd_data, b_rd_strb, k);
      end
      b_rd_addr = 4'(k + 1);
    end
  endtask

  task automatic test_full_priority();
    int acc = 0, first_c = -1, last_c = -1;
    for (int c = 0; acc < 16 && c < 2000; c++) begin
      @(negedge clk);
      c_tvalid = 1'b1; c_tdata = acc; c_tstrb = 4'hF; c_tlast = 1'b0;
      #1;
      if (c_tready) begin
        if (acc == 0) first_c = c;
        acc++;
        last_c = c;
      end
    end
    checks++;
    if (acc != 16 || first_c != 1 || last_c != 316) begin
      failures++;
      $display("FAIL full_prio_timing beats=%0d first=%0d last=%0d required 16/1/316", acc, first_c, last_c);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (c_stall !== 1'b0 || c_tready !== 1'b0 || c_done !== 1'b1 || c_ovf !== (i >= 1)
          || c_beats !== 5'd16) begin
        failures++;
        $display("FAIL full_prio cycle %0d: stall=%b tready=%b done=%b ovf=%b beats=%0d required 0/0/1/%b/16",
                 i, c_stall, c_tready, c_done, c_ovf, c_beats, (i >= 1));
      end
    end
  endtask

  task automatic test_clear_mid_stall();
    int acc = 0;
    bit exp_r;
    @(negedge clk);
    c_clear = 1'b1; c_tvalid = 1'b1;
    #1;
    checks++;
    if (c_ovf !== 1'b1 || c_tready !== 1'b0) begin
      failures++;
      $display("FAIL clear_full_pre ovf=%b tready=%b required 1/0", c_ovf, c_tready);
    end
    @(negedge clk);
    c_clear = 1'b0; c_tvalid = 1'b0;
    #1;
    checks++;
    if (c_ovf !== 1'b0 || c_done !== 1'b0 || c_beats !== 5'd0) begin
      failures++;
      $display("FAIL clear_full ovf=%b done=%b beats=%0d required 0/0/0", c_ovf, c_done, c_beats);
    end
    for (int c = 0; c <= 54; c++) begin
      @(negedge clk);
      c_tvalid = 1'b1; c_tdata = 32'h100 + acc;
      c_clear = (c == 54);
      #1;
      exp_r = (c >= 1) && (c <= 4) && (c != 54);
      checks++;
      if (c_tready !== exp_r || c_stall !== (c >= 5)) begin
        failures++;
        $display("FAIL clear_stall_run cycle %0d: tready=%b stall=%b required %b/%b",
                 c, c_tready, c_stall, exp_r, (c >= 5));
      end
      if (exp_r) acc++;
    end
    @(negedge clk);
    c_clear = 1'b0; c_tvalid = 1'b0;
    #1;
    checks++;
    if (c_stall !== 1'b0 || c_tready !== 1'b0 || c_beats !== 5'd0 || c_pkts !== 16'd0
        || c_ovf !== 1'b0 || c_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_stall_state stall=%b tready=%b beats=%0d pkts=%0d ovf=%b done=%b required zeros",
               c_stall, c_tready, c_beats, c_pkts, c_ovf, c_done);
    end
    acc = 0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      c_tvalid = 1'b1; c_tdata = 32'h200 + acc;
      #1;
      exp_r = (c >= 1) && (c <= 4);
      checks++;
      if (c_tready !== exp_r || c_stall !== (c == 5)) begin
        failures++;
        $display("FAIL clear_restart cycle %0d: tready=%b stall=%b required %b/%b",
                 c, c_tready, c_stall, exp_r, (c == 5));
      end
      if (exp_r) acc++;
    end
    c_tvalid = 1'b0;
    c_rd_addr = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (c_rd_data !== 32'h200 + 32'(k)) begin
        failures++;
        $display("FAIL clear_restart_read addr %0d: got %h required %h", k, c_rd_data, 32'h200 + k);
      end
      c_rd_addr = 4'(k + 1);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_tvalid = 1'b0; a_tlast = 1'b0; a_clear = 1'b0;
    a_tdata = '0; a_tstrb = '0; a_rd_addr = '0;
    b_rst = 1'b1; b_tvalid = 1'b0; b_tlast = 1'b0; b_clear = 1'b0;
    b_tdata = '0; b_tstrb = '0; b_rd_addr = '0;
    c_rst = 1'b1; c_tvalid = 1'b0; c_tlast = 1'b0; c_clear = 1'b0;
    c_tdata = '0; c_tstrb = '0; c_rd_addr = '0;
    test_reset();
    test_stall_pattern();
    test_tlast_random();
    test_reset_mid_recv();
    test_no_stall_full();
    test_full_priority();
    test_clear_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
